// File: rtl/pll_clk_monitor.sv
// ---------------------------------------------------------------------------
// pll_clk_monitor
//
// Frequency-lock checker running on the PLL output clock. The PLL reference
// clock is treated as asynchronous data: it is synchronised, its rising edges
// are counted over a fixed window of CLK cycles, and the count is compared
// against an expected band. After LOCK_COUNT consecutive in-band windows the
// monitor declares lock and releases a downstream reset. An out-of-band
// window while locked drops lock, pulses LOSS and sets the sticky FAULT.
//
// Parameters
//   WINDOW_CYCLES  CLK cycles per measurement window (>= 2)
//   EXPECTED       nominal REF_CLK rising edges per window
//   TOLERANCE      allowed +/- deviation from EXPECTED
//   LOCK_COUNT     consecutive good windows needed for lock (>= 1)
//   CNT_W          width of the edge counter and FREQ_COUNT
//
// Ports
//   CLK         in   system clock (PLL CLKOP)
//   RSTN        in   asynchronous active-low reset
//   REF_CLK     in   asynchronous reference clock, sampled as data
//   ENABLE      in   monitor enable (level)
//   CLR_FAULT   in   single-cycle pulse, clears FAULT
//   LOCKED      out  frequency-lock status
//   RST_OUT_N   out  downstream reset, LOCKED delayed by one cycle
//   FREQ_COUNT  out  edge count of the last completed window
//   VALID       out  one-cycle pulse, FREQ_COUNT just updated
//   LOSS        out  one-cycle pulse on the locked -> unlocked transition
//   FAULT       out  sticky loss-of-lock flag
// ---------------------------------------------------------------------------
module pll_clk_monitor #(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned EXPECTED      = 200,
  parameter int unsigned TOLERANCE     = 2,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             REF_CLK,
  input  logic             ENABLE,
  input  logic             CLR_FAULT,
  output logic             LOCKED,
  output logic             RST_OUT_N,
  output logic [CNT_W-1:0] FREQ_COUNT,
  output logic             VALID,
  output logic             LOSS,
  output logic             FAULT
);

  localparam int unsigned WC_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned GC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW_CYCLES - 1);
  localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_COUNT);

  // Acceptance band, fixed at elaboration; the lower bound clamps at zero.
  localparam logic [63:0] LO_B = (EXPECTED > TOLERANCE) ? 64'(EXPECTED - TOLERANCE) : 64'd0;
  localparam logic [63:0] HI_B = 64'(EXPECTED) + 64'(TOLERANCE);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED_S = 2'd2
  } state_t;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (v == '1) return v;
    return v + CNT_W'(inc);
  endfunction

  function automatic logic in_band(input logic [CNT_W-1:0] c);
    logic [63:0] c64;
    c64 = 64'(c);
    return (c64 >= LO_B) && (c64 <= HI_B);
  endfunction

  logic             ref_p0, ref_p1, ref_p2;
  logic             rise_p2;
  state_t           state, state_nxt;
  logic [GC_W-1:0]  good_cnt, gc_nxt, gc_inc;
  logic [WC_W-1:0]  wcnt;
  logic [CNT_W-1:0] ecnt;
  logic [CNT_W-1:0] win_count;
  logic             win_end;
  logic             win_good;
  logic             running;
  logic             loss_nxt;
  logic             fault_nxt;

  // --- stage p0..p2: REF_CLK synchroniser and rising-edge detect ----------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ref_p0 <= 1'b0;
      ref_p1 <= 1'b0;
      ref_p2 <= 1'b0;
    end else begin
      ref_p0 <= REF_CLK;
      ref_p1 <= ref_p0;
      ref_p2 <= ref_p1;
    end
  end

  assign rise_p2 = ref_p1 & ~ref_p2;

  // --- window counting ------------------------------------------------------
  // Counters only run while enabled and out of DISABLED; dropping ENABLE
  // discards the partial window.
  assign running   = ENABLE && (state != DISABLED);
  assign win_end   = running && (wcnt == WC_LAST);
  // An edge landing on the last cycle still belongs to the closing window.
  assign win_count = sat_inc(ecnt, rise_p2);
  assign win_good  = in_band(win_count);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wcnt       <= '0;
      ecnt       <= '0;
      FREQ_COUNT <= '0;
      VALID      <= 1'b0;
    end else begin
      VALID <= win_end;
      if (!running) begin
        wcnt <= '0;
        ecnt <= '0;
      end else if (win_end) begin
        wcnt       <= '0;
        ecnt       <= '0;
        FREQ_COUNT <= win_count;
      end else begin
        wcnt <= wcnt + 1'b1;
        ecnt <= sat_inc(ecnt, rise_p2);
      end
    end
  end

  // --- lock state machine ---------------------------------------------------
  // The decision is taken on the closing edge of a window so that LOCKED,
  // LOSS and FAULT change in the same cycle VALID is presented.
  always_comb begin
    state_nxt = state;
    gc_nxt    = good_cnt;
    loss_nxt  = 1'b0;
    gc_inc    = (good_cnt == GC_LOCK) ? good_cnt : good_cnt + 1'b1;

    if (!ENABLE) begin
      state_nxt = DISABLED;
      gc_nxt    = '0;
    end else begin
      case (state)
        DISABLED: begin
          state_nxt = ACQUIRE;
          gc_nxt    = '0;
        end
        ACQUIRE: begin
          if (win_end) begin
            if (win_good) begin
              gc_nxt = gc_inc;
              if (gc_inc == GC_LOCK) state_nxt = LOCKED_S;
            end else begin
              gc_nxt = '0;
            end
          end
        end
        LOCKED_S: begin
          if (win_end && !win_good) begin
            state_nxt = ACQUIRE;
            gc_nxt    = '0;
            loss_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = DISABLED;
          gc_nxt    = '0;
        end
      endcase
    end

    // A loss event in the same cycle as CLR_FAULT keeps the fault set.
    if (loss_nxt)       fault_nxt = 1'b1;
    else if (CLR_FAULT) fault_nxt = 1'b0;
    else                fault_nxt = FAULT;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= DISABLED;
      good_cnt <= '0;
      LOSS     <= 1'b0;
      FAULT    <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= gc_nxt;
      LOSS     <= loss_nxt;
      FAULT    <= fault_nxt;
    end
  end

  assign LOCKED = (state == LOCKED_S);

  // --- downstream reset: released one cycle after lock, reasserted one cycle
  // after lock is lost --------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) RST_OUT_N <= 1'b0;
    else       RST_OUT_N <= LOCKED;
  end

endmodule

// File: tb/tb_pll_clk_monitor.sv
`timescale 1ns/1ps
module tb_pll_clk_monitor;

  localparam int W    = 100;
  localparam int EXP  = 20;
  localparam int TOL  = 2;
  localparam int LCK  = 4;
  localparam int CW   = 16;
  localparam int CW2  = 4;
  localparam int LO   = (EXP > TOL) ? EXP - TOL : 0;
  localparam int HI   = EXP + TOL;
  localparam int MAXV = (1 << CW) - 1;
  localparam int MAXV2 = (1 << CW2) - 1;
  localparam int MAXC = 40000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ref_clk = 1'b0;
  logic enable = 1'b0;
  logic clr_fault = 1'b0;

  logic          locked, rst_out_n, valid, loss, fault;
  logic [CW-1:0] freq_count;
  logic           locked2, rst_out_n2, valid2, loss2, fault2;
  logic [CW2-1:0] freq_count2;

  pll_clk_monitor #(.WINDOW_CYCLES(W), .EXPECTED(EXP), .TOLERANCE(TOL),
                    .LOCK_COUNT(LCK), .CNT_W(CW)) dut (
    .CLK(clk), .RSTN(rstn), .REF_CLK(ref_clk), .ENABLE(enable),
    .CLR_FAULT(clr_fault), .LOCKED(locked), .RST_OUT_N(rst_out_n),
    .FREQ_COUNT(freq_count), .VALID(valid), .LOSS(loss), .FAULT(fault));

  // Narrow-counter instance: 20 edges per window must saturate at 15.
  pll_clk_monitor #(.WINDOW_CYCLES(W), .EXPECTED(EXP), .TOLERANCE(TOL),
                    .LOCK_COUNT(LCK), .CNT_W(CW2)) dut_sat (
    .CLK(clk), .RSTN(rstn), .REF_CLK(ref_clk), .ENABLE(enable),
    .CLR_FAULT(clr_fault), .LOCKED(locked2), .RST_OUT_N(rst_out_n2),
    .FREQ_COUNT(freq_count2), .VALID(valid2), .LOSS(loss2), .FAULT(fault2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start = 0;
  int rate = 0;
  int acc = 0;
  int cnt_at[MAXC];

  typedef struct {
    int cnt;
    int lk;
    int ls;
    int ft;
  } exp_t;
  exp_t q1[$];
  int   q2[$];

  // reference model state (as seen after the most recent rising edge)
  int m_locked = 0, m_rst = 0, m_fault = 0, m_loss = 0, m_valid = 0;
  int m_freq = 0, m_freq2 = 0, run = 0;
  bit active = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // REF_CLK generator: a phase accumulator produces rate/10 rising edges per
  // W cycles. Each edge is logged at the clock edge where the monitor should
  // accumulate it (sampled next edge, +2 through the synchroniser).
  always @(negedge clk) begin
    ref_clk = 1'b0;
    acc += rate;
    if (acc >= 1000) begin
      acc -= 1000;
      ref_clk = 1'b1;
      if (cyc + 3 < MAXC) cnt_at[cyc + 3]++;
    end
  end

  // Behavioural reference: windows are intervals of W clock edges after the
  // enable edge; the count is the number of logged edges inside the interval.
  always @(posedge clk) begin : model
    int c;
    bit good;
    bit lossev;
    cyc++;
    m_rst   = m_locked;
    m_loss  = 0;
    m_valid = 0;
    if (!rstn) begin
      active = 1'b0; run = 0; m_locked = 0; m_rst = 0; m_fault = 0;
      m_freq = 0; m_freq2 = 0;
    end else begin
      lossev = 1'b0;
      if (!active) begin
        if (enable) begin
          active = 1'b1;
          start  = cyc;
          run    = 0;
        end
      end else if (!enable) begin
        active = 1'b0;
        run = 0;
        m_locked = 0;
      end else if (((cyc - start) % W) == 0) begin
        c = 0;
        for (int k = cyc - W + 1; k <= cyc; k++) c += cnt_at[k];
        good = (c >= LO) && (c <= HI);
        if (good) begin
          run++;
          if (run >= LCK) m_locked = 1;
        end else begin
          run = 0;
          if (m_locked != 0) begin
            m_locked = 0;
            lossev = 1'b1;
          end
        end
        m_valid = 1;
        m_loss  = lossev ? 1 : 0;
        m_freq  = (c > MAXV) ? MAXV : c;
        m_freq2 = (c > MAXV2) ? MAXV2 : c;
      end
      if (lossev) m_fault = 1;
      else if (clr_fault) m_fault = 0;
      if (m_valid != 0) begin
        q1.push_back('{m_freq, m_locked, m_loss, m_fault});
        q2.push_back(m_freq2);
      end
    end
  end

  // Monitor: per-cycle status against the model, window results from the
  // scoreboard whenever a DUT presents VALID.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   e2;
    chk("locked", locked, m_locked);
    chk("rst_out_n", rst_out_n, m_rst);
    chk("fault", fault, m_fault);
    chk("loss", loss, m_loss);
    chk("valid", valid, m_valid);
    chk("freq_hold", freq_count, m_freq);
    chk("valid_sat", valid2, m_valid);
    if (valid) begin
      if (q1.size() == 0) chk("valid_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("win_count", freq_count, e.cnt);
        chk("win_locked", locked, e.lk);
        chk("win_loss", loss, e.ls);
        chk("win_fault", fault, e.ft);
      end
    end
    if (valid2) begin
      if (q2.size() == 0) chk("valid_sat_unexpected", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("sat_count", freq_count2, e2);
        chk("sat_locked", locked2, 0);
        chk("sat_fault", fault2 | loss2 | rst_out_n2, 0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the falling edge just before the edge that closes a window.
  task automatic to_pre_end();
    int i;
    i = 0;
    while ((((cyc + 1 - start) % W) != 0) && (i <= W)) begin
      @(negedge clk);
      i++;
    end
    if (i > W) chk("window_align", i, W);
  endtask

  task automatic windows(input int r, input int n);
    rate = r;
    repeat (n) begin
      @(negedge clk);
      to_pre_end();
    end
  endtask

  initial begin
    #(10 * 50000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rates[8];
    rates = '{170, 180, 200, 220, 230, 202, 150, 250};
    acc = int'($urandom_range(0, 999));

    // reset state
    cycles(3);
    chk("rst_locked", locked, 0);
    chk("rst_rst_out_n", rst_out_n, 0);
    chk("rst_freq", freq_count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_loss", loss, 0);
    chk("rst_fault", fault, 0);

    // ideal reference: lock on 4th window
    rstn = 1'b1;
    enable = 1'b1;
    windows(200, 6);
    chk("ideal_locked", locked, 1);

    // reference stops: loss and fault, then relock with fault held
    windows(0, 2);
    windows(200, 6);

    // CLR_FAULT alone
    cycles(int'($urandom_range(10, 40)));
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("fault_cleared", fault, 0);

    // CLR_FAULT coincident with a loss event
    to_pre_end();
    rate = 0;
    @(negedge clk);
    to_pre_end();
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("set_wins_fault", fault, 1);
    chk("set_wins_loss", loss, 1);

    // three good, one bad, then good windows
    windows(200, 3);
    windows(150, 1);
    windows(200, 5);

    // enable dropped mid-window while locked
    cycles(int'($urandom_range(30, 70)));
    enable = 1'b0;
    @(negedge clk);
    chk("dis_locked", locked, 0);
    chk("dis_valid", valid, 0);
    cycles(20);
    enable = 1'b1;
    windows(200, 5);

    // band edges and randomised rates
    repeat (14) windows(rates[$urandom_range(0, 7)], 2);
    windows(200, 5);

    // asynchronous reset mid-window
    rate = 0;
    cycles(30);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_rst_out_n", rst_out_n, 0);
    chk("mid_rst_freq", freq_count, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_valid", valid | loss, 0);
    cycles(3);
    rstn = 1'b1;
    windows(200, 5);
    chk("relock_after_rst", locked, 1);

    enable = 1'b0;
    cycles(5);
    chk("scoreboard_drained", q1.size() + q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_clk_monitor.md
Name: pll_clk_monitor

Overview:
- Consumer-side checker for the PLL clock generator. Runs on the PLL output clock CLKOP (100 MHz).
- Treats the 20 MHz PLL reference input as asynchronous data, samples it, and counts its rising edges over a fixed window of CLK cycles.
- Declares lock after consecutive in-tolerance windows and drives a synchronous-deassert reset for downstream DSP logic.
- Flags loss of lock with a sticky fault.

Parameters:
WINDOW_CYCLES, 1000, CLK cycles per measurement window (>=2)
EXPECTED, 200, expected REF_CLK rising edges per window
TOLERANCE, 2, allowed +/- deviation from EXPECTED
LOCK_COUNT, 4, consecutive good windows required to declare lock (>=1)
CNT_W, 16, width of edge counter and FREQ_COUNT

Ports:
CLK  input  1  system clock (PLL CLKOP)
RSTN  input  1  asynchronous active-low reset
REF_CLK  input  1  asynchronous reference clock, sampled as data
ENABLE  input  1  monitor enable, level
CLR_FAULT  input  1  single-cycle pulse, clears FAULT
LOCKED  output  1  frequency-lock status
RST_OUT_N  output  1  downstream reset, low until LOCKED
FREQ_COUNT  output  CNT_W  edge count of the last completed window
VALID  output  1  one-cycle pulse: FREQ_COUNT updated
LOSS  output  1  one-cycle pulse on the LOCKED->unlocked transition
FAULT  output  1  sticky loss-of-lock flag

Behaviour:
- Reset (RSTN low, async): all flops 0. LOCKED=0, RST_OUT_N=0, FREQ_COUNT=0, VALID=0, LOSS=0, FAULT=0, state=DISABLED.
- Input path: 3-flop chain s1->s2->s3. rise = s2 & ~s3. A REF_CLK rising edge is counted 2-3 CLK cycles after it occurs.
- Window counter wcnt runs 0..WINDOW_CYCLES-1, then wraps to 0. Edge counter ecnt increments on rise and saturates at 2^CNT_W-1.
- Window end (wcnt==WINDOW_CYCLES-1):
  - FREQ_COUNT <= sat(ecnt + rise). The edge on the last cycle belongs to the closing window.
  - ecnt <= 0.
  - VALID=1 on the following cycle, for one cycle.
  - good = (EXPECTED-TOLERANCE <= count <= EXPECTED+TOLERANCE), computed on the same registered count.
- State machine (good_cnt counts consecutive good windows, saturating at LOCK_COUNT):
  - DISABLED: wcnt, ecnt and good_cnt held at 0; LOCKED=0. ENABLE=1 -> ACQUIRE. The first window starts with wcnt=0 on the next cycle.
  - ACQUIRE: on a good window, good_cnt++. When good_cnt reaches LOCK_COUNT -> LOCKED_S, and LOCKED=1 in the same cycle VALID=1. On a bad window, good_cnt=0 and the state stays ACQUIRE.
  - LOCKED_S: a good window keeps the state. A bad window -> ACQUIRE with good_cnt=0, LOCKED=0, LOSS=1 for one cycle, FAULT=1. All of these occur in the VALID cycle.
  - ENABLE=0 in any state -> DISABLED next cycle. The partial window is discarded with no VALID. LOCKED drops without LOSS or FAULT. FREQ_COUNT keeps its last value.
- RST_OUT_N = LOCKED delayed one cycle. It deasserts synchronously and asserts one cycle after LOCKED falls.
- FAULT: set by the loss event, cleared by CLR_FAULT. If both occur in the same cycle, set wins.
- Arithmetic: unsigned. Compare bounds are computed at elaboration. If EXPECTED < TOLERANCE, the lower bound clamps to 0.
- RSTN asserted mid-window: immediate return to the reset state. No VALID or LOSS is emitted.

Test Plan:
- Ideal 20 MHz REF_CLK, ENABLE=1 -> each window FREQ_COUNT=200 with a VALID pulse every 1000 cycles. LOCKED rises with the 4th VALID. RST_OUT_N rises 1 cycle later. LOSS=0 and FAULT=0 throughout.
- REF_CLK at 20.2 MHz (202/window) -> lock after 4 windows. REF_CLK at 21 MHz (210/window) -> FREQ_COUNT=210, LOCKED never asserts.
- Locked, then REF_CLK stopped -> next window FREQ_COUNT=0 (or the partial count); LOCKED=0, one-cycle LOSS, FAULT=1. RST_OUT_N falls 1 cycle later. Restore REF_CLK -> relock after 4 good windows while FAULT stays 1.
- CLR_FAULT pulsed alone -> FAULT=0. CLR_FAULT coincident with a loss event -> FAULT=1.
- Good windows 3 in a row, then one bad (150), then good -> good_cnt resets. LOCKED asserts only at the 4th consecutive good window after the bad one.
- ENABLE dropped at wcnt=500 while locked -> LOCKED=0 next cycle, no VALID/LOSS/FAULT, FREQ_COUNT unchanged. Re-enable -> first VALID 1000 cycles later. Also: CNT_W=4 with 20 edges/window -> FREQ_COUNT saturates at 15.
